// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving the IFU and the LSU exclusive, per-transaction ownership
// of one memory port, with a watchdog that reclaims a grant whose mem_finish never comes.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ifu_arvalid,
  output logic              ifu_arready,
  input  logic [ADDR_W-1:0] ifu_araddr,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic              ifu_memfinish,
  input  logic              lsu_arvalid,
  output logic              lsu_arready,
  input  logic              lsu_awvalid,
  output logic              lsu_awready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [2:0]        lsu_memop,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_memfinish,
  output logic              mem_arvalid,
  input  logic              mem_arready,
  output logic              mem_awvalid,
  input  logic              mem_awready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_memop,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_finish,
  output logic              bus_err
);

  localparam bit              WD_EN   = (TIMEOUT > 0);
  localparam int              WD_W    = WD_EN ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_EN ? WD_W'(TIMEOUT - 1) : '0;
  localparam logic [WD_W-1:0] WD_MAX  = '1;
  localparam logic [2:0]      IFU_MEMOP = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_OWN_IFU = 2'd1,
    S_OWN_LSU = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_last_grant;
  logic [WD_W-1:0] r_wd_cnt;
  logic            r_bus_err;

  logic w_ifu_req;
  logic w_lsu_req;
  logic w_owned;
  logic w_wd_expire;

  assign w_ifu_req   = ifu_arvalid;
  assign w_lsu_req   = lsu_arvalid | lsu_awvalid;
  assign w_owned     = (r_state == S_OWN_IFU) || (r_state == S_OWN_LSU);
  assign w_wd_expire = WD_EN && w_owned && !mem_finish && (r_wd_cnt == WD_LAST);

  // last_grant resets to LSU so the IFU wins the very first tie
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_wd_cnt     <= '0;
      r_bus_err    <= 1'b0;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_wd_cnt <= '0;
          if (w_ifu_req && (!w_lsu_req || r_last_grant))
            r_state <= S_OWN_IFU;
          else if (w_lsu_req)
            r_state <= S_OWN_LSU;
        end
        S_OWN_IFU, S_OWN_LSU: begin
          if (mem_finish || w_wd_expire) begin
            r_bus_err    <= !mem_finish;
            r_state      <= S_IDLE;
            r_last_grant <= (r_state == S_OWN_LSU);
            r_wd_cnt     <= '0;
          end else if (r_wd_cnt != WD_MAX) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Request/handshake routing follows the registered owner; non-owners see zeros
  always_comb begin
    mem_arvalid   = 1'b0;
    mem_awvalid   = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_memop     = 3'b000;
    ifu_arready   = 1'b0;
    ifu_memfinish = 1'b0;
    lsu_arready   = 1'b0;
    lsu_awready   = 1'b0;
    lsu_memfinish = 1'b0;
    case (r_state)
      S_OWN_IFU: begin
        mem_arvalid   = ifu_arvalid;
        mem_addr      = ifu_araddr;
        mem_memop     = IFU_MEMOP;
        ifu_arready   = mem_arready;
        ifu_memfinish = mem_finish;
      end
      S_OWN_LSU: begin
        mem_arvalid   = lsu_arvalid;
        mem_awvalid   = lsu_awvalid;
        mem_addr      = lsu_addr;
        mem_wdata     = lsu_wdata;
        mem_memop     = lsu_memop;
        lsu_arready   = mem_arready;
        lsu_awready   = mem_awready;
        lsu_memfinish = mem_finish;
      end
      default: ;
    endcase
  end

  assign ifu_rdata = mem_rdata;
  assign lsu_rdata = mem_rdata;
  assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Cycle-table bench for mem_arbiter (TIMEOUT=4) with a TIMEOUT=0 twin sharing its inputs.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [AW-1:0] IFU_ADDR = 32'h8000_0000;
  localparam logic [AW-1:0] LSU_ADDR = 32'h8000_1000;
  localparam logic [DW-1:0] LSU_DATA = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, ifu_arvalid, lsu_arvalid, lsu_awvalid;
  logic          mem_arready, mem_awready, mem_finish;
  logic [AW-1:0] ifu_araddr, lsu_addr;
  logic [DW-1:0] lsu_wdata, mem_rdata;
  logic [2:0]    lsu_memop;

  logic          ifu_arready, ifu_memfinish, lsu_arready, lsu_awready, lsu_memfinish;
  logic          mem_arvalid, mem_awvalid, bus_err;
  logic [DW-1:0] ifu_rdata, lsu_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [2:0]    mem_memop;

  logic          ifu_arready0, ifu_memfinish0, lsu_arready0, lsu_awready0, lsu_memfinish0;
  logic          mem_arvalid0, mem_awvalid0, bus_err0;
  logic [DW-1:0] ifu_rdata0, lsu_rdata0, mem_wdata0;
  logic [AW-1:0] mem_addr0;
  logic [2:0]    mem_memop0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
    .ifu_rdata(ifu_rdata), .ifu_memfinish(ifu_memfinish),
    .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_awvalid(lsu_awvalid),
    .lsu_awready(lsu_awready), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_memop(lsu_memop), .lsu_rdata(lsu_rdata), .lsu_memfinish(lsu_memfinish),
    .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_awvalid(mem_awvalid),
    .mem_awready(mem_awready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_memop(mem_memop), .mem_rdata(mem_rdata), .mem_finish(mem_finish),
    .bus_err(bus_err)
  );

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready0), .ifu_araddr(ifu_araddr),
    .ifu_rdata(ifu_rdata0), .ifu_memfinish(ifu_memfinish0),
    .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready0), .lsu_awvalid(lsu_awvalid),
    .lsu_awready(lsu_awready0), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_memop(lsu_memop), .lsu_rdata(lsu_rdata0), .lsu_memfinish(lsu_memfinish0),
    .mem_arvalid(mem_arvalid0), .mem_arready(mem_arready), .mem_awvalid(mem_awvalid0),
    .mem_awready(mem_awready), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .mem_memop(mem_memop0), .mem_rdata(mem_rdata), .mem_finish(mem_finish),
    .bus_err(bus_err0)
  );

  // in  = {rst_n, ifu_arvalid, lsu_arvalid, lsu_awvalid, mem_arready, mem_awready, mem_finish}
  // own = expected owner during the row: 0 idle, 1 IFU, 2 LSU
  // exp = {mem_arvalid, mem_awvalid, ifu_arready, ifu_memfinish,
  //        lsu_arready, lsu_awready, lsu_memfinish, bus_err}
  typedef struct packed {
    logic [6:0] in;
    logic [2:0] op;
    logic [1:0] own;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic row(input logic [6:0] in, input logic [2:0] op,
                     input logic [1:0] own, input logic [7:0] exp);
    vec_t v;
    v.in = in; v.op = op; v.own = own; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [2:0]    e_op;
    int            owned_cycles;
    bit            err_seen, fin_seen;

    // reset and basic IFU fetch
    row(7'b0_000_000, 3'd0, 2'd0, 8'h00);
    row(7'b1_100_000, 3'd0, 2'd0, 8'h00);
    row(7'b1_100_100, 3'd0, 2'd1, 8'hA0);
    row(7'b1_000_000, 3'd0, 2'd1, 8'h00);
    row(7'b1_000_001, 3'd0, 2'd1, 8'h10);
    row(7'b1_000_000, 3'd0, 2'd0, 8'h00);
    // tie after reset: IFU, then tie again: LSU while IFU keeps pulsing, then IFU
    row(7'b0_000_000, 3'd0, 2'd0, 8'h00);
    row(7'b1_110_000, 3'd5, 2'd0, 8'h00);
    row(7'b1_110_100, 3'd5, 2'd1, 8'hA0);
    row(7'b1_010_001, 3'd5, 2'd1, 8'h10);
    row(7'b1_110_000, 3'd5, 2'd0, 8'h00);
    row(7'b1_110_100, 3'd5, 2'd2, 8'h88);
    row(7'b1_100_100, 3'd5, 2'd2, 8'h08);
    row(7'b1_000_001, 3'd5, 2'd2, 8'h02);
    row(7'b1_110_000, 3'd5, 2'd0, 8'h00);
    row(7'b1_110_100, 3'd5, 2'd1, 8'hA0);
    row(7'b1_010_001, 3'd5, 2'd1, 8'h10);
    row(7'b1_000_000, 3'd0, 2'd0, 8'h00);
    // LSU store, then stray finish in IDLE
    row(7'b1_001_000, 3'd2, 2'd0, 8'h00);
    row(7'b1_001_000, 3'd2, 2'd2, 8'h40);
    row(7'b1_001_010, 3'd2, 2'd2, 8'h44);
    row(7'b1_000_001, 3'd2, 2'd2, 8'h02);
    row(7'b1_000_001, 3'd0, 2'd0, 8'h00);
    // watchdog expiry after 4 owned cycles
    row(7'b1_100_000, 3'd0, 2'd0, 8'h00);
    row(7'b1_100_100, 3'd0, 2'd1, 8'hA0);
    row(7'b1_000_000, 3'd0, 2'd1, 8'h00);
    row(7'b1_000_000, 3'd0, 2'd1, 8'h00);
    row(7'b1_000_000, 3'd0, 2'd1, 8'h00);
    row(7'b1_000_000, 3'd0, 2'd0, 8'h01);
    row(7'b1_000_000, 3'd0, 2'd0, 8'h00);
    // finish coinciding with expiry: finish wins
    row(7'b1_100_000, 3'd0, 2'd0, 8'h00);
    row(7'b1_100_100, 3'd0, 2'd1, 8'hA0);
    row(7'b1_000_000, 3'd0, 2'd1, 8'h00);
    row(7'b1_000_000, 3'd0, 2'd1, 8'h00);
    row(7'b1_000_001, 3'd0, 2'd1, 8'h10);
    row(7'b1_000_000, 3'd0, 2'd0, 8'h00);
    // reset while LSU owns, stray finish, then normal grant
    row(7'b1_010_000, 3'd4, 2'd0, 8'h00);
    row(7'b1_010_100, 3'd4, 2'd2, 8'h88);
    row(7'b0_000_000, 3'd4, 2'd2, 8'h00);
    row(7'b1_000_001, 3'd4, 2'd0, 8'h00);
    row(7'b1_010_000, 3'd4, 2'd0, 8'h00);
    row(7'b1_010_100, 3'd4, 2'd2, 8'h88);
    row(7'b1_000_001, 3'd4, 2'd2, 8'h02);
    row(7'b1_000_000, 3'd0, 2'd0, 8'h00);

    rst_n = 1'b0; ifu_arvalid = 1'b0; lsu_arvalid = 1'b0; lsu_awvalid = 1'b0;
    mem_arready = 1'b0; mem_awready = 1'b0; mem_finish = 1'b0;
    ifu_araddr = IFU_ADDR; lsu_addr = LSU_ADDR; lsu_wdata = LSU_DATA;
    lsu_memop = 3'd0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      {rst_n, ifu_arvalid, lsu_arvalid, lsu_awvalid, mem_arready, mem_awready, mem_finish} = vecs[i].in;
      lsu_memop = vecs[i].op;
      mem_rdata = 32'hA500_0000 + 32'(i);
      @(negedge clk);
      case (vecs[i].own)
        2'd1:    begin e_addr = IFU_ADDR; e_wdata = '0;       e_op = 3'b010;      end
        2'd2:    begin e_addr = LSU_ADDR; e_wdata = LSU_DATA; e_op = vecs[i].op; end
        default: begin e_addr = '0;       e_wdata = '0;       e_op = 3'b000;      end
      endcase
      chk($sformatf("row%0d ctrl", i),
          {mem_arvalid, mem_awvalid, ifu_arready, ifu_memfinish,
           lsu_arready, lsu_awready, lsu_memfinish, bus_err}, vecs[i].exp);
      chk($sformatf("row%0d route", i), {mem_addr, mem_wdata, mem_memop}, {e_addr, e_wdata, e_op});
      chk($sformatf("row%0d rdata", i), {ifu_rdata, lsu_rdata}, {mem_rdata, mem_rdata});
      chk($sformatf("row%0d wd_off bus_err", i), bus_err0, 1'b0);
      @(posedge clk);
      #1;
    end

    // IFU holds valid with no ready and no finish; count owned cycles until the watchdog fires
    {rst_n, ifu_arvalid, lsu_arvalid, lsu_awvalid, mem_arready, mem_awready, mem_finish} = 7'b1_100_000;
    owned_cycles = 0; err_seen = 1'b0; fin_seen = 1'b0;
    for (int c = 0; c < 20 && !err_seen; c++) begin
      @(negedge clk);
      if (ifu_memfinish) fin_seen = 1'b1;
      if (bus_err) err_seen = 1'b1;
      else if (mem_arvalid) owned_cycles++;
      if (!err_seen) begin
        @(posedge clk);
        #1;
      end
    end
    chk("hang bus_err within bound", err_seen, 1'b1);
    chk("hang owned cycles", owned_cycles, 4);
    chk("hang no ifu_memfinish", fin_seen, 1'b0);
    chk("hang wd_off keeps grant", mem_arvalid0, 1'b1);
    chk("hang idle on bus_err", {mem_arvalid, mem_addr}, {1'b0, 32'h0});
    ifu_arvalid = 1'b0;
    mem_finish  = 1'b1;
    @(posedge clk);
    #1;
    mem_finish = 1'b0;
    @(negedge clk);
    chk("bus_err single cycle", bus_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master, one-slave arbiter for the shared instruction/data memory port.
- Masters are the IFU (read-only fetch) and the LSU (loads and stores); the slave is the memory interface that returns a one-cycle memfinish pulse.
- Grants are owned per transaction, round-robin on contention, with a watchdog that releases a hung grant.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, max granted cycles without mem_finish; 0 disables watchdog

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- ifu_arvalid  in  1  IFU fetch request
- ifu_arready  out  1  IFU address accepted by memory
- ifu_araddr  in  ADDR_W  fetch address
- ifu_rdata  out  DATA_W  fetch data
- ifu_memfinish  out  1  fetch complete pulse
- lsu_arvalid  in  1  LSU load request
- lsu_arready  out  1  LSU load address accepted
- lsu_awvalid  in  1  LSU store request
- lsu_awready  out  1  LSU store address accepted
- lsu_addr  in  ADDR_W  load/store address
- lsu_wdata  in  DATA_W  store data
- lsu_memop  in  3  access size/sign code
- lsu_rdata  out  DATA_W  load data
- lsu_memfinish  out  1  LSU access complete pulse
- mem_arvalid  out  1  read request to memory
- mem_arready  in  1  memory accepts read address
- mem_awvalid  out  1  write request to memory
- mem_awready  in  1  memory accepts write address
- mem_addr  out  ADDR_W  address to memory
- mem_wdata  out  DATA_W  write data to memory
- mem_memop  out  3  access code to memory
- mem_rdata  in  DATA_W  read data from memory
- mem_finish  in  1  memory transaction done, 1-cycle pulse
- bus_err  out  1  watchdog expiry pulse

Behaviour:
- State machine states: IDLE, OWN_IFU, OWN_LSU. Registers: state, last_grant (0=IFU, 1=LSU), wd_cnt.
- Reset (rst_n=0 at posedge): state=IDLE, last_grant=1 so IFU wins the first tie, wd_cnt=0, bus_err=0. Reset mid-transaction drops the grant immediately. A later mem_finish for the dropped access is ignored.

IDLE:
- ifu_req=ifu_arvalid; lsu_req=lsu_arvalid|lsu_awvalid.
- Only one request: go to that owner.
- Both requests: grant the master that is not last_grant.
- Neither request: stay in IDLE.
- Grant is registered: memory sees the request 1 cycle after the request is first seen in IDLE.

Routing:
- All mem_* outputs and the masters' ready/memfinish are 0 in IDLE.
- OWN_IFU:
  - mem_arvalid=ifu_arvalid, mem_awvalid=0, mem_addr=ifu_araddr, mem_memop=3'b010, mem_wdata=0.
  - ifu_arready=mem_arready, ifu_memfinish=mem_finish.
- OWN_LSU:
  - mem_arvalid=lsu_arvalid, mem_awvalid=lsu_awvalid, mem_addr=lsu_addr, mem_wdata=lsu_wdata, mem_memop=lsu_memop.
  - lsu_arready=mem_arready, lsu_awready=mem_awready, lsu_memfinish=mem_finish.
- Non-owner ready/memfinish are held at 0.
- ifu_rdata and lsu_rdata both equal mem_rdata at all times. Data is valid only with the matching memfinish.
- The owner keeps valid high until ready. Once the handshake is done, valid may drop; the grant holds until mem_finish.

Release:
- On mem_finish while owned: next state IDLE, last_grant=owner, wd_cnt=0.
- At least 1 IDLE cycle separates back-to-back grants.
- mem_finish in IDLE is ignored.

Watchdog:
- wd_cnt increments each owned cycle without mem_finish.
- When wd_cnt reaches TIMEOUT-1 (TIMEOUT>0), the next edge does the following: bus_err=1 for 1 cycle, state=IDLE, last_grant=owner, wd_cnt=0. No memfinish is issued.
- wd_cnt saturates rather than wrapping; its width is clog2(TIMEOUT+1).
- TIMEOUT=0: the watchdog never fires.

Simultaneous events:
- mem_finish in the same cycle as watchdog expiry: the finish wins and bus_err stays 0.
- lsu_arvalid and lsu_awvalid both high: forwarded unchanged (LSU protocol violation; not resolved here).

Test Plan:
- Reset, then ifu_arvalid=1 addr=0x80000000, mem_arready=1 at cycle 2, mem_finish at cycle 4 -> mem_arvalid rises 1 cycle after request, mem_memop=3'b010, ifu_memfinish pulses at cycle 4, state back to IDLE at cycle 5.
- IFU and LSU request in the same cycle after reset -> IFU granted first. LSU granted after IFU's mem_finish plus 1 IDLE cycle. Repeating the tie then grants LSU.
- LSU store addr=0x80001000 wdata=0xDEADBEEF memop=3'b010 -> mem_awvalid=1, mem_wdata=0xDEADBEEF, lsu_awready mirrors mem_awready, ifu_* ready/finish stay 0.
- LSU read is owned while ifu_arvalid pulses -> ifu_arready=0 and no IFU address reaches memory until LSU completes.
- TIMEOUT=4, IFU granted, mem_finish never arrives -> bus_err=1 for exactly 1 cycle after 4 owned cycles, state IDLE, ifu_memfinish never asserted.
- rst_n=0 for 1 cycle while OWN_LSU, then stray mem_finish -> all outputs 0, no lsu_memfinish pulse, next request granted normally.
